block_nest_checker: RTL and testbench
=====================================

// Module: block_nest_checker
// PURPOSE
//  Streaming checker for keyword nesting in an ASCII character stream, one char per valid cycle.
//  Tracks begin/end and, when enabled, fork/join pairs on a type stack of depth MAX_DEPTH.
//  Reports whether the stream so far is balanced, plus the current depth and a sticky error code.
//  Sits after the character source in the P1 text-checker family.
// PARAMETERS
//  MAX_DEPTH        16  max open blocks; localparam DEPTH_W = $clog2(MAX_DEPTH+1)
//  CASE_INSENSITIVE 1   1: A-Z folded to a-z before matching; 0: exact lowercase keywords only
//  ENABLE_FORK      1   1: fork/join recognised as a second pair type; 0: plain words
// PORTS
//  clk       in   1        clock, rising edge
//  reset     in   1        asynchronous, active-high; clears all state
//  in        in   8        ASCII character
//  in_valid  in   1        in is consumed this cycle; low = hold every register
//  result    out  1        1 = balanced, no error (see lookahead)
//  depth     out  DEPTH_W  committed open-block count
//  err       out  1        sticky error flag
//  err_code  out  2        00 none, 01 underflow, 10 type mismatch, 11 overflow
// BEHAVIOUR
//  - Reset values: depth=0, err=0, err_code=00, stack cleared, word tracker idle, result=1.
//  - Letter = A-Z or a-z; any other byte is a delimiter. A word is a maximal run of letters.
//  - Word tracker: per letter, updates match state for begin/end/fork/join. Any mismatch or
//    extra letters mark the word as NONE. A case mismatch with CASE_INSENSITIVE=0 also gives NONE.
//  - Commit: on a valid delimiter, a pending word that fully matches a keyword acts in that same edge:
//    - opener, depth<MAX_DEPTH: push type (0=begin, 1=fork) and depth+1.
//    - opener, depth==MAX_DEPTH: overflow (11).
//    - closer, depth==0: underflow (01).
//    - closer, top type differs: mismatch (10).
//    - closer, top type matches: pop and depth-1.
//  - Errors: the first error is latched in err_code. After any error, the stack, depth and err are frozen.
//  - Lookahead: result is combinational. Let P = the pending full-match keyword (none if mid-word or NONE).
//    - err=1 -> 0.
//    - no P -> (depth==0).
//    - P opener -> 0.
//    - P closer -> 1 iff depth==1 and the top type matches; else 0.
//    Lookahead never sets err: a later letter turns P back into NONE.
//  - A pending word at end of stream is never committed. result still shows its lookahead value.
//  - ENABLE_FORK=0: fork/join are NONE and the stack carries no type; only begin/end count.
//  - One char per cycle, so no simultaneous push/pop. in_valid=0 mid-word keeps the word pending.
//  - Async reset mid-word or mid-error returns to reset values on the next cycle.
//  - Latency: depth/err update on the clock edge that consumes the delimiter.
//    result tracks the consumed char in the same cycle it is registered.
//  - Widths: depth saturates by rule (overflow error), never wraps. The stack is MAX_DEPTH x 1 bit.
// STRUCTURE
//  - Shared package bnc_pkg:
//    - ASCII constants (space, A/Z, a/z, keyword letters).
//    - Keyword enum {KW_NONE, KW_BEGIN, KW_END, KW_FORK, KW_JOIN}.
//    - err_code constants.
//  - Sub-module bnc_word_matcher: case folding and the keyword match state machine.
//    Outputs kw and a pending flag. Top level holds the stack, depth, error logic and result.
// TESTING
//  1. Sequence below, with each word followed by a space:
//     - reset, then "begin" (not yet terminated) -> result=0, depth=0.
//     - space -> depth=1, result=0.
//     - "end" -> result=1 before its space.
//     - space -> depth=0, result=1.
//  2. "endx " -> NONE word, result=1, err=0.
//     "end " with depth 0 -> err=1, err_code=01; result stays 0 after a further "begin end ".
//  3. "Begin fork join END " (CASE_INSENSITIVE=1) -> depth 1,2,1,0, result=1.
//     Same stream with CASE_INSENSITIVE=0 -> Begin/END are ignored, depth 0,1,0,0, result=1.
//  4. "begin join " -> err_code=10, depth frozen at 1.
//     With ENABLE_FORK=0 the same stream gives depth=1, err=0, result=0.
//  5. MAX_DEPTH=4, five "begin " words -> depth=4, then err_code=11.
//  6. in_valid low for 3 cycles inside "beg|in" -> "begin " still commits, depth=1.
//     Assert reset mid-word -> all outputs return to reset values.

Source files
------------

// File: rtl/bnc_pkg.sv
// Shared definitions for the block nesting checker.
// ASCII constants, keyword codes, error codes and character helpers.
package bnc_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_UA    = 8'h41;
    localparam logic [7:0] ASCII_UZ    = 8'h5A;
    localparam logic [7:0] ASCII_LA    = 8'h61;
    localparam logic [7:0] ASCII_LZ    = 8'h7A;
    localparam logic [7:0] CASE_OFS    = 8'h20;

    localparam logic [7:0] CH_B = 8'h62;
    localparam logic [7:0] CH_D = 8'h64;
    localparam logic [7:0] CH_E = 8'h65;
    localparam logic [7:0] CH_F = 8'h66;
    localparam logic [7:0] CH_G = 8'h67;
    localparam logic [7:0] CH_I = 8'h69;
    localparam logic [7:0] CH_J = 8'h6A;
    localparam logic [7:0] CH_K = 8'h6B;
    localparam logic [7:0] CH_N = 8'h6E;
    localparam logic [7:0] CH_O = 8'h6F;
    localparam logic [7:0] CH_R = 8'h72;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNDER    = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;
    localparam logic [1:0] ERR_OVER     = 2'b11;

    typedef enum logic [2:0] {
        KW_NONE,
        KW_BEGIN,
        KW_END,
        KW_FORK,
        KW_JOIN
    } kw_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WORD,
        W_NONE
    } wstate_e;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_UA) && (c <= ASCII_UZ);
    endfunction

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= ASCII_LA) && (c <= ASCII_LZ);
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return is_upper(c) || is_lower(c);
    endfunction

    // Keyword index: 0 begin, 1 end, 2 fork, 3 join
    function automatic logic [2:0] kw_len(input logic [1:0] k);
        logic [2:0] n;
        unique case (k)
            2'd0:    n = 3'd5;
            2'd1:    n = 3'd3;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] kw_char(input logic [1:0] k,
                                           input logic [2:0] i);
        logic [7:0] c;
        c = 8'h00;
        unique case (k)
            2'd0: case (i)
                3'd0:    c = CH_B;
                3'd1:    c = CH_E;
                3'd2:    c = CH_G;
                3'd3:    c = CH_I;
                3'd4:    c = CH_N;
                default: c = 8'h00;
            endcase
            2'd1: case (i)
                3'd0:    c = CH_E;
                3'd1:    c = CH_N;
                3'd2:    c = CH_D;
                default: c = 8'h00;
            endcase
            2'd2: case (i)
                3'd0:    c = CH_F;
                3'd1:    c = CH_O;
                3'd2:    c = CH_R;
                3'd3:    c = CH_K;
                default: c = 8'h00;
            endcase
            default: case (i)
                3'd0:    c = CH_J;
                3'd1:    c = CH_O;
                3'd2:    c = CH_I;
                3'd3:    c = CH_N;
                default: c = 8'h00;
            endcase
        endcase
        return c;
    endfunction

endpackage

// File: rtl/block_nest_checker_if.sv
// Character stream in, nesting status out.
// The source drives master; the checker is the slave.
interface block_nest_checker_if #(
    parameter int DEPTH_W = 5
);
    logic [7:0]         in;
    logic               in_valid;
    logic               result;
    logic [DEPTH_W-1:0] depth;
    logic               err;
    logic [1:0]         err_code;

    modport master (
        output in, in_valid,
        input  result, depth, err, err_code
    );

    modport slave (
        input  in, in_valid,
        output result, depth, err, err_code
    );
endinterface

// File: rtl/block_nest_checker_word_matcher.sv
// Keyword recogniser: folds case and tracks which keywords
// the current word could still be, one letter at a time.
module bnc_word_matcher
    import bnc_pkg::*;
#(
    parameter bit CASE_INSENSITIVE = 1'b1,
    parameter bit ENABLE_FORK      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ch_i,
    input  logic       valid_i,
    output kw_e        kw_o,
    output logic       pending_o
);

    // bit0 begin, bit1 end, bit2 fork, bit3 join
    localparam logic [3:0] CAND_INIT =
        ENABLE_FORK ? 4'b1111 : 4'b0011;

    wstate_e    state_q, state_d;
    logic [2:0] pos_q, pos_d;
    logic [3:0] cand_q, cand_d;

    logic [7:0] folded;
    logic       letter;
    logic [3:0] base_cand;
    logic [2:0] base_pos;
    logic [3:0] step;

    assign letter = is_letter(ch_i);
    assign folded = (CASE_INSENSITIVE && is_upper(ch_i))
                  ? ch_i + CASE_OFS : ch_i;

    // Match state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= W_IDLE;
            pos_q   <= 3'd0;
            cand_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cand_q  <= cand_d;
        end
    end

    // Narrow the candidate set by one letter, or close the word
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        cand_d    = cand_q;
        base_cand = (state_q == W_IDLE) ? CAND_INIT : cand_q;
        base_pos  = (state_q == W_IDLE) ? 3'd0 : pos_q;
        for (int k = 0; k < 4; k++) begin
            step[k] = base_cand[k]
                   && (base_pos < kw_len(2'(k)))
                   && (folded == kw_char(2'(k), base_pos));
        end
        if (valid_i) begin
            if (!letter) begin
                state_d = W_IDLE;
                pos_d   = 3'd0;
                cand_d  = 4'd0;
            end else if (state_q != W_NONE) begin
                if (step == 4'd0) begin
                    state_d = W_NONE;
                    pos_d   = 3'd0;
                    cand_d  = 4'd0;
                end else begin
                    state_d = W_WORD;
                    pos_d   = base_pos + 3'd1;
                    cand_d  = step;
                end
            end
        end
    end

    // A keyword is pending when a surviving candidate is complete
    always_comb begin
        kw_o = KW_NONE;
        if (state_q == W_WORD) begin
            if (cand_q[0] && pos_q == kw_len(2'd0))
                kw_o = KW_BEGIN;
            else if (cand_q[1] && pos_q == kw_len(2'd1))
                kw_o = KW_END;
            else if (cand_q[2] && pos_q == kw_len(2'd2))
                kw_o = KW_FORK;
            else if (cand_q[3] && pos_q == kw_len(2'd3))
                kw_o = KW_JOIN;
        end
    end

    assign pending_o = (state_q != W_IDLE);

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end (and fork/join) nesting checker.
// Holds the type stack, depth, sticky error and lookahead result.
module block_nest_checker
    import bnc_pkg::*;
#(
    parameter int MAX_DEPTH        = 16,
    parameter bit CASE_INSENSITIVE = 1'b1,
    parameter bit ENABLE_FORK      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    block_nest_checker_if.slave  bus
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int IDX_W   = $clog2(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    kw_e  kw;
    logic pending;

    logic [MAX_DEPTH-1:0] stack_q, stack_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;

    logic             is_open, is_close, kw_type;
    logic             full, empty, top_type, commit;
    logic [IDX_W-1:0] top_idx, push_idx;
    logic             result_c;

    bnc_word_matcher #(
        .CASE_INSENSITIVE (CASE_INSENSITIVE),
        .ENABLE_FORK      (ENABLE_FORK)
    ) u_match (
        .clk       (clk),
        .reset     (reset),
        .ch_i      (bus.in),
        .valid_i   (bus.in_valid),
        .kw_o      (kw),
        .pending_o (pending)
    );

    assign is_open  = (kw == KW_BEGIN) || (kw == KW_FORK);
    assign is_close = (kw == KW_END) || (kw == KW_JOIN);
    assign kw_type  = (kw == KW_FORK) || (kw == KW_JOIN);
    assign full     = (depth_q == DEPTH_MAX);
    assign empty    = (depth_q == '0);
    assign top_idx  = IDX_W'(depth_q - DEPTH_ONE);
    assign push_idx = IDX_W'(depth_q);
    assign top_type = stack_q[top_idx];
    assign commit   = bus.in_valid && !is_letter(bus.in) && !err_q;

    // Nesting state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stack_q <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            stack_q <= stack_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // Apply a completed keyword on its delimiter; errors freeze state
    always_comb begin
        stack_d = stack_q;
        depth_d = depth_q;
        err_d   = err_q;
        code_d  = code_q;
        if (commit) begin
            unique case (1'b1)
                is_open && !full: begin
                    stack_d[push_idx] = kw_type;
                    depth_d = depth_q + DEPTH_ONE;
                end
                is_open && full: begin
                    err_d  = 1'b1;
                    code_d = ERR_OVER;
                end
                is_close && empty: begin
                    err_d  = 1'b1;
                    code_d = ERR_UNDER;
                end
                is_close && !empty && top_type != kw_type: begin
                    err_d  = 1'b1;
                    code_d = ERR_MISMATCH;
                end
                is_close && !empty && top_type == kw_type: begin
                    depth_d = depth_q - DEPTH_ONE;
                end
                default: ;
            endcase
        end
    end

    // Lookahead: balanced if the pending keyword were committed now
    always_comb begin
        result_c = 1'b0;
        if (err_q)
            result_c = 1'b0;
        else if (!pending || kw == KW_NONE)
            result_c = empty;
        else if (is_open)
            result_c = 1'b0;
        else
            result_c = (depth_q == DEPTH_ONE)
                    && (stack_q[0] == kw_type);
    end

    assign bus.result   = result_c;
    assign bus.depth    = depth_q;
    assign bus.err      = err_q;
    assign bus.err_code = code_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// Self-checking bench for block_nest_checker.
// Four parameterisations share one stream against a string model.
module tb_block_nest_checker;

    typedef struct packed {
        logic [1:0] cfg;
        logic       res;
        logic [4:0] dep;
        logic       e;
        logic [1:0] code;
    } snap_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] ch = 8'h20;
    logic vld = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    int MAXD[4] = '{16, 16, 16, 4};
    int CI[4]   = '{1, 0, 1, 1};
    int FE[4]   = '{1, 1, 0, 1};

    int         m_depth[4];
    bit         m_err[4];
    logic [1:0] m_code[4];
    bit         m_stk[4][16];
    string      m_word[4];

    snap_t expq[$];
    snap_t obsq[$];

    always #5 clk = ~clk;

    block_nest_checker_if #(.DEPTH_W(5)) if0 ();
    block_nest_checker_if #(.DEPTH_W(5)) if1 ();
    block_nest_checker_if #(.DEPTH_W(5)) if2 ();
    block_nest_checker_if #(.DEPTH_W(3)) if3 ();

    assign if0.in = ch;
    assign if1.in = ch;
    assign if2.in = ch;
    assign if3.in = ch;
    assign if0.in_valid = vld;
    assign if1.in_valid = vld;
    assign if2.in_valid = vld;
    assign if3.in_valid = vld;

    block_nest_checker #(.MAX_DEPTH(16), .CASE_INSENSITIVE(1'b1),
        .ENABLE_FORK(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    block_nest_checker #(.MAX_DEPTH(16), .CASE_INSENSITIVE(1'b0),
        .ENABLE_FORK(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    block_nest_checker #(.MAX_DEPTH(16), .CASE_INSENSITIVE(1'b1),
        .ENABLE_FORK(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    block_nest_checker #(.MAX_DEPTH(4), .CASE_INSENSITIVE(1'b1),
        .ENABLE_FORK(1'b1)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    function automatic bit is_let(input byte c);
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    // 0 none, 1 begin, 2 end, 3 fork, 4 join
    function automatic int classify(input string w, input int k);
        string t;
        t = (CI[k] != 0) ? w.tolower() : w;
        if (t == "begin") return 1;
        if (t == "end") return 2;
        if (FE[k] != 0 && t == "fork") return 3;
        if (FE[k] != 0 && t == "join") return 4;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_depth[k] = 0;
            m_err[k] = 1'b0;
            m_code[k] = 2'b00;
            m_word[k] = "";
            for (int j = 0; j < 16; j++) m_stk[k][j] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int k, input byte c);
        int kw;
        bit ty;
        if (is_let(c)) begin
            m_word[k] = $sformatf("%s%c", m_word[k], c);
            return;
        end
        kw = classify(m_word[k], k);
        m_word[k] = "";
        ty = (kw == 3 || kw == 4);
        if (m_err[k] || kw == 0) return;
        if (kw == 1 || kw == 3) begin
            if (m_depth[k] == MAXD[k]) begin
                m_err[k] = 1'b1;
                m_code[k] = 2'b11;
            end else begin
                m_stk[k][m_depth[k]] = ty;
                m_depth[k]++;
            end
        end else if (m_depth[k] == 0) begin
            m_err[k] = 1'b1;
            m_code[k] = 2'b01;
        end else if (m_stk[k][m_depth[k]-1] != ty) begin
            m_err[k] = 1'b1;
            m_code[k] = 2'b10;
        end else begin
            m_depth[k]--;
        end
    endfunction

    function automatic snap_t model_snap(input int k);
        snap_t s;
        int kw;
        kw = classify(m_word[k], k);
        s.cfg = 2'(k);
        s.dep = 5'(m_depth[k]);
        s.e = m_err[k];
        s.code = m_code[k];
        if (m_err[k]) s.res = 1'b0;
        else if (kw == 0) s.res = (m_depth[k] == 0);
        else if (kw == 1 || kw == 3) s.res = 1'b0;
        else s.res = (m_depth[k] == 1)
                  && (m_stk[k][0] == (kw == 4));
        return s;
    endfunction

    function automatic snap_t dut_snap(input int k);
        snap_t s;
        s.cfg = 2'(k);
        case (k)
            0: begin
                s.res = if0.result; s.dep = if0.depth;
                s.e = if0.err; s.code = if0.err_code;
            end
            1: begin
                s.res = if1.result; s.dep = if1.depth;
                s.e = if1.err; s.code = if1.err_code;
            end
            2: begin
                s.res = if2.result; s.dep = if2.depth;
                s.e = if2.err; s.code = if2.err_code;
            end
            default: begin
                s.res = if3.result; s.dep = {2'b00, if3.depth};
                s.e = if3.err; s.code = if3.err_code;
            end
        endcase
        return s;
    endfunction

    task automatic send(input byte c, input bit v);
        @(negedge clk);
        ch = c;
        vld = v;
        for (int k = 0; k < 4; k++) begin
            if (v) model_step(k, c);
            expq.push_back(model_snap(k));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) obsq.push_back(dut_snap(k));
        vld = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        vld = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) expq.push_back(model_snap(k));
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) obsq.push_back(dut_snap(k));
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        snap_t e, o;
        apply_reset();
        while (expq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset cfg%0d got r%b d%0d e%b c%b want r%b d%0d e%b c%b",
                    e.cfg, o.res, o.dep, o.e, o.code, e.res, e.dep, e.e, e.code);
            end
        end
    endtask

    task automatic test_basic();
        snap_t e, o;
        apply_reset();
        send_str("begin");
        send_str(" ");
        send_str("end");
        send_str(" ");
        while (expq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL basic cfg%0d got r%b d%0d e%b c%b want r%b d%0d e%b c%b",
                    e.cfg, o.res, o.dep, o.e, o.code, e.res, e.dep, e.e, e.code);
            end
        end
        n_cmp++;
        if (if0.depth !== 5'd0 || if0.result !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_end depth=%0d result=%b want 0 1",
                if0.depth, if0.result);
        end
    endtask

    task automatic test_underflow();
        snap_t e, o;
        apply_reset();
        send_str("endx ");
        send_str("end ");
        send_str("begin end ");
        while (expq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL underflow cfg%0d got r%b d%0d e%b c%b want r%b d%0d e%b c%b",
                    e.cfg, o.res, o.dep, o.e, o.code, e.res, e.dep, e.e, e.code);
            end
        end
        n_cmp++;
        if (if0.err_code !== 2'b01 || if0.result !== 1'b0) begin
            n_bad++;
            $display("FAIL underflow_code code=%b result=%b want 01 0",
                if0.err_code, if0.result);
        end
    endtask

    task automatic test_case_fork();
        snap_t e, o;
        apply_reset();
        send_str("Begin fork join END ");
        while (expq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL case_fork cfg%0d got r%b d%0d e%b c%b want r%b d%0d e%b c%b",
                    e.cfg, o.res, o.dep, o.e, o.code, e.res, e.dep, e.e, e.code);
            end
        end
    endtask

    task automatic test_mismatch();
        snap_t e, o;
        apply_reset();
        send_str("begin join ");
        while (expq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL mismatch cfg%0d got r%b d%0d e%b c%b want r%b d%0d e%b c%b",
                    e.cfg, o.res, o.dep, o.e, o.code, e.res, e.dep, e.e, e.code);
            end
        end
        n_cmp++;
        if (if0.err_code !== 2'b10 || if2.err !== 1'b0
            || if2.depth !== 5'd1) begin
            n_bad++;
            $display("FAIL mismatch_cfg code0=%b err2=%b depth2=%0d want 10 0 1",
                if0.err_code, if2.err, if2.depth);
        end
    endtask

    task automatic test_overflow();
        snap_t e, o;
        apply_reset();
        for (int i = 0; i < 5; i++) send_str("begin ");
        while (expq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL overflow cfg%0d got r%b d%0d e%b c%b want r%b d%0d e%b c%b",
                    e.cfg, o.res, o.dep, o.e, o.code, e.res, e.dep, e.e, e.code);
            end
        end
        n_cmp++;
        if (if3.err_code !== 2'b11 || if3.depth !== 3'd4) begin
            n_bad++;
            $display("FAIL overflow_d4 code=%b depth=%0d want 11 4",
                if3.err_code, if3.depth);
        end
    endtask

    task automatic test_hold_and_reset();
        snap_t e, o;
        apply_reset();
        send_str("beg");
        for (int i = 0; i < 3; i++) send("x", 1'b0);
        send_str("in ");
        send_str("fo");
        apply_reset();
        send_str("begin");
        apply_reset();
        send_str("end ");
        apply_reset();
        while (expq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL hold_reset cfg%0d got r%b d%0d e%b c%b want r%b d%0d e%b c%b",
                    e.cfg, o.res, o.dep, o.e, o.code, e.res, e.dep, e.e, e.code);
            end
        end
    endtask

    task automatic test_back_to_back();
        snap_t e, o;
        string words[12];
        string dl;
        words = '{"begin", "end", "fork", "join", "Begin", "END",
                  "beginx", "x", "en", "joint", "FORK", "Join"};
        dl = " ,;1\n";
        apply_reset();
        for (int i = 0; i < 120; i++) begin
            if (i % 15 == 14) apply_reset();
            send_str(words[$urandom_range(0, 11)]);
            send(dl[$urandom_range(0, 4)], 1'b1);
            if ($urandom_range(0, 3) == 0) send("q", 1'b0);
        end
        while (expq.size() != 0) begin
            e = expq.pop_front(); o = obsq.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL b2b cfg%0d got r%b d%0d e%b c%b want r%b d%0d e%b c%b",
                    e.cfg, o.res, o.dep, o.e, o.code, e.res, e.dep, e.e, e.code);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_underflow();
        test_case_fork();
        test_mismatch();
        test_overflow();
        test_hold_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_bad);
        $finish;
    end

endmodule
